// File: rtl/sec_notas_pkg.sv
// sec_notas_pkg: note index encoding and sequencing helper shared by the tone sequencer
package sec_notas_pkg;
    localparam int NUM_NOTES = 3;
    localparam logic [1:0] NOTE0 = 2'd0;
    localparam logic [1:0] NOTE1 = 2'd1;
    localparam logic [1:0] NOTE2 = 2'd2;
    // Last note and the unreachable code 3 both return to note 0
    function automatic logic [1:0] next_note(input logic [1:0] i);
        return (i >= 2'(NUM_NOTES - 1)) ? NOTE0 : i + 2'd1;
    endfunction
endpackage

// File: rtl/sec_notas_tone_div.sv
// sec_notas_tone_div: half-period divider with a registered square-wave output
//   clk, rst   : clock, synchronous active-high reset
//   sync_clr   : restart the tone low and in phase (note change strobe)
//   half       : half-period in clock cycles, >= 1
//   tone       : registered square-wave output
module tone_div #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sync_clr,
    input  logic [W-1:0] half,
    output logic         tone
);
    logic [W-1:0] tcnt;
    always_ff @(posedge clk) begin
        if (rst || sync_clr) begin
            tcnt <= '0;
            tone <= 1'b0;
        end else if (tcnt == half - 1'b1) begin
            tcnt <= '0;
            tone <= ~tone;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end
endmodule

// File: rtl/sec_notas.sv
// sec_notas: three-note square-wave tone sequencer, each note held for DUR cycles
//   clk    : system clock
//   rst    : synchronous active-high reset
//   ch_out : registered square-wave audio output
module sec_notas
    import sec_notas_pkg::*;
#(
    parameter int N0  = 11467,
    parameter int N1  = 10216,
    parameter int N2  = 9101,
    parameter int DUR = 6000000
) (
    input  logic clk,
    input  logic rst,
    output logic ch_out
);
    localparam int NMAX = (N0 > N1) ? ((N0 > N2) ? N0 : N2) : ((N1 > N2) ? N1 : N2);
    localparam int DW   = $clog2(DUR + 1);
    localparam int TW   = $clog2(NMAX + 1);
    logic [DW-1:0] dcnt;
    logic [1:0]    idx;
    logic          note_chg;
    logic [TW-1:0] nsel;
    // Code 3 is treated as a pending note change so the sequencer self-recovers
    always_comb begin
        note_chg = (dcnt == DW'(DUR - 1)) || (idx == 2'd3);
        nsel     = (idx == NOTE0) ? TW'(N0) : (idx == NOTE1) ? TW'(N1) : TW'(N2);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt <= '0;
            idx  <= NOTE0;
        end else if (note_chg) begin
            dcnt <= '0;
            idx  <= next_note(idx);
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end
    // Note change wins over a toggle due on the same edge: every note starts low
    tone_div #(.W(TW)) u_div (
        .clk     (clk),
        .rst     (rst),
        .sync_clr(note_chg),
        .half    (nsel),
        .tone    (ch_out)
    );
endmodule

// File: tb/tb_sec_notas.sv
// tb_sec_notas: directed and randomized checks of sec_notas against a time-based reference model
module tb_sec_notas;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ch_a, ch_b, ch_c, ch_d;
    int   checks = 0;
    int   fails  = 0;
    int   k_a    = 0;
    int   k_b    = 0;
    int   k_c    = 0;
    int   k_d    = 0;

    always #5 clk = ~clk;

    sec_notas #(.N0(4), .N1(3), .N2(2), .DUR(10)) dut_a (.clk(clk), .rst(rst), .ch_out(ch_a));
    sec_notas #(.N0(5), .N1(3), .N2(2), .DUR(10)) dut_b (.clk(clk), .rst(rst), .ch_out(ch_b));
    sec_notas #(.N0(1), .N1(1), .N2(1), .DUR(1))  dut_c (.clk(clk), .rst(rst), .ch_out(ch_c));
    sec_notas #(.N0(7), .N1(2), .N2(5), .DUR(23)) dut_d (.clk(clk), .rst(rst), .ch_out(ch_d));

    // Reference: after edge k since reset, the note is (k/DUR) mod 3, and t = k mod DUR
    // edges into it; the tone has completed floor(t/N) half-periods from a low start.
    function automatic void model(input int k, input int n0, input int n1, input int n2,
                                  input int dur, output logic ch, output int idx);
        int t;
        int n;
        idx = (k / dur) % 3;
        t   = k % dur;
        n   = (idx == 0) ? n0 : (idx == 1) ? n1 : n2;
        ch  = ((t / n) % 2) == 1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (k_a=%0d)", tag, obs, exp, k_a);
        end
    endtask

    task automatic check_all();
        logic ch;
        int   idx;
        model(k_a, 4, 3, 2, 10, ch, idx);
        chk("a_ch", int'(ch_a), int'(ch));
        chk("a_idx", int'(dut_a.idx), idx);
        model(k_b, 5, 3, 2, 10, ch, idx);
        chk("b_ch", int'(ch_b), int'(ch));
        chk("b_idx", int'(dut_b.idx), idx);
        model(k_c, 1, 1, 1, 1, ch, idx);
        chk("c_ch", int'(ch_c), int'(ch));
        chk("c_idx", int'(dut_c.idx), idx);
        model(k_d, 7, 2, 5, 23, ch, idx);
        chk("d_ch", int'(ch_d), int'(ch));
        chk("d_idx", int'(dut_d.idx), idx);
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        #1;
        k_a = r ? 0 : k_a + 1;
        k_b = r ? 0 : k_b + 1;
        k_c = r ? 0 : k_c + 1;
        k_d = r ? 0 : k_d + 1;
        check_all();
    endtask

    initial begin
        int rise_at;
        logic prev;
        step(1'b1);
        step(1'b1);
        chk("rst_ch", int'(ch_a), 0);
        chk("rst_dcnt", int'(dut_a.dcnt), 0);
        // Directed edge landmarks for the 4/3/2/10 configuration
        for (int e = 1; e <= 40; e++) begin
            step(1'b0);
            if (e == 4 || e == 13 || e == 19 || e == 22 || e == 26 || e == 34)
                chk("rise_edge", int'(ch_a), 1);
            if (e == 8 || e == 16 || e == 20 || e == 24 || e == 28 || e == 30)
                chk("low_edge", int'(ch_a), 0);
            if (e == 10) begin
                chk("trunc_idx", int'(dut_b.idx), 1);
                chk("trunc_ch", int'(ch_b), 0);
            end
        end
        // Note wrap over 100 further cycles: change edges must show low output
        for (int e = 0; e < 100; e++) begin
            step(1'b0);
            if (k_a % 10 == 0) chk("chg_low", int'(ch_a), 0);
        end
        // Mid-note reset at edge 15
        step(1'b1);
        for (int e = 1; e <= 14; e++) step(1'b0);
        step(1'b1);
        chk("mid_idx", int'(dut_a.idx), 0);
        chk("mid_ch", int'(ch_a), 0);
        rise_at = 0;
        prev = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step(1'b0);
            if (ch_a && !prev && rise_at == 0) rise_at = e;
            prev = ch_a;
        end
        chk("mid_first_rise", rise_at, 4);
        // Reset held for 50 edges: everything stays cleared
        for (int e = 0; e < 50; e++) begin
            step(1'b1);
            chk("hold_tcnt", int'(dut_a.u_div.tcnt), 0);
            chk("hold_dcnt_d", int'(dut_d.dcnt), 0);
        end
        // Randomized run with sporadic resets
        for (int e = 0; e < 600; e++) step($urandom_range(0, 49) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
